// File: rtl/wb_arbiter_2m.sv
// Two-requester Wishbone arbiter: round-robin on ties, grant held for the
// whole cycle, and a stall timeout that aborts the owner with a one-cycle error.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Abort fires on the edge where the stall count would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic        last_grant_r;
  logic [7:0]  tmo_cnt_r;
  logic        own_cyc_s;
  logic        other_cyc_s;
  logic        stall_s;

  // Shared-port mux: the granted requester drives the bus, everything else is zero.
  always_comb begin
    wbm_adr_o = 32'd0;
    wbm_dat_o = 32'd0;
    wbm_sel_o = 4'd0;
    wbm_we_o  = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cyc_o = 1'b0;
    case (state_r)
      GNT0: begin
        wbm_adr_o = m0_adr_i;
        wbm_dat_o = m0_dat_i;
        wbm_sel_o = m0_sel_i;
        wbm_we_o  = m0_we_i;
        wbm_stb_o = m0_stb_i;
        wbm_cyc_o = m0_cyc_i;
      end
      GNT1: begin
        wbm_adr_o = m1_adr_i;
        wbm_dat_o = m1_dat_i;
        wbm_sel_o = m1_sel_i;
        wbm_we_o  = m1_we_i;
        wbm_stb_o = m1_stb_i;
        wbm_cyc_o = m1_cyc_i;
      end
      default: begin
        wbm_cyc_o = 1'b0;
      end
    endcase
  end

  // Owner/other cycle requests seen from the current grant.
  always_comb begin
    if (state_r == GNT1) begin
      own_cyc_s   = m1_cyc_i;
      other_cyc_s = m0_cyc_i;
    end else begin
      own_cyc_s   = m0_cyc_i;
      other_cyc_s = m1_cyc_i;
    end
  end

  assign stall_s  = wbm_stb_o & ~wbm_ack_i;
  assign m0_ack_o = (state_r == GNT0) & wbm_ack_i;
  assign m1_ack_o = (state_r == GNT1) & wbm_ack_i;
  assign m0_err_o = (state_r == ABORT) & ~last_grant_r;
  assign m1_err_o = (state_r == ABORT) &  last_grant_r;
  // Read data is broadcast; held at zero only while reset is asserted.
  assign m0_dat_o = wb_rst_n_i ? wbm_dat_i : 32'd0;
  assign m1_dat_o = wb_rst_n_i ? wbm_dat_i : 32'd0;

  // Arbitration FSM with round-robin memory and stall timeout counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      tmo_cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          tmo_cnt_r <= 8'd0;
          if (m0_cyc_i && m1_cyc_i) begin
            if (last_grant_r) begin
              state_r      <= GNT0;
              last_grant_r <= 1'b0;
            end else begin
              state_r      <= GNT1;
              last_grant_r <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state_r      <= GNT0;
            last_grant_r <= 1'b0;
          end else if (m1_cyc_i) begin
            state_r      <= GNT1;
            last_grant_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GNT0, GNT1: begin
          // Release is checked first so a drop on the timeout cycle never errors.
          if (!own_cyc_s) begin
            tmo_cnt_r <= 8'd0;
            if (other_cyc_s) begin
              state_r      <= (state_r == GNT0) ? GNT1 : GNT0;
              last_grant_r <= (state_r == GNT0);
            end else begin
              state_r <= IDLE;
            end
          end else if (stall_s) begin
            if (tmo_cnt_r == TMO_LAST) begin
              state_r   <= ABORT;
              tmo_cnt_r <= 8'd0;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
          end else begin
            tmo_cnt_r <= 8'd0;
          end
        end
        ABORT: begin
          state_r   <= IDLE;
          tmo_cnt_r <= 8'd0;
        end
        default: begin
          state_r   <= IDLE;
          tmo_cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait for wbm_ack_i, in cycles, while wbm_stb_o is high (range 1..255).
REQ-002 SHALL have port wb_clk_i  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port wb_rst_n_i  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports mN_adr_i / mN_dat_i  in  32/32  requester N address / write data (N=0,1).
REQ-005 SHALL have ports mN_sel_i  in  4, and mN_we_i / mN_stb_i / mN_cyc_i  in  1 each  requester N byte select / write / strobe / cycle (N=0,1).
REQ-006 SHALL have ports mN_dat_o  out  32, and mN_ack_o / mN_err_o  out  1 each  read data / acknowledge / timeout error to requester N (N=0,1).
REQ-007 SHALL have ports wbm_adr_o / wbm_dat_o  out  32/32, wbm_sel_o  out  4, and wbm_we_o / wbm_stb_o / wbm_cyc_o  out  1 each  shared Wishbone master port.
REQ-008 SHALL have ports wbm_dat_i  in  32 and wbm_ack_i  in  1  shared port read data / acknowledge.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT; state register only, no other storage of bus payload.
REQ-010 IDLE: if exactly one mN_cyc_i is high, the FSM SHALL go to GNTN on the next edge.
REQ-011 IDLE with both cyc high: the FSM SHALL grant the requester not equal to last_grant (round-robin); last_grant SHALL update on entry to GNTN.
REQ-012 In GNTN, wbm_adr/dat/sel/we_o SHALL equal requester N's inputs combinationally; wbm_cyc_o = mN_cyc_i; wbm_stb_o = mN_stb_i.
REQ-013 Outside GNT0/GNT1, wbm_cyc_o and wbm_stb_o SHALL be 0; wbm_adr/dat/sel/we_o SHALL be 0.
REQ-014 mN_ack_o SHALL equal wbm_ack_i in GNTN only, and 0 otherwise; mN_dat_o SHALL equal wbm_dat_i for both N at all times.
REQ-015 Grant latency: the first cycle of wbm_cyc_o high SHALL be the cycle after the edge that samples the request in IDLE.
REQ-016 The grant SHALL be held while mN_cyc_i is high, including across multiple stb/ack beats; there SHALL be no preemption.
REQ-017 In GNTN with mN_cyc_i low: if the other requester's cyc is high, the FSM SHALL go directly to GNT(other); otherwise it SHALL go to IDLE.
REQ-018 The timeout counter (8 bits) SHALL increment each cycle that wbm_stb_o=1 and wbm_ack_i=0.
REQ-019 The timeout counter SHALL clear on wbm_ack_i, on wbm_stb_o=0, and on any state change.
REQ-020 When the counter reaches TIMEOUT in GNTN, the FSM SHALL go to ABORT; in ABORT, mN_err_o SHALL be 1 for exactly one cycle (N = last_grant), and the next state SHALL be IDLE.
REQ-021 mN_err_o SHALL be 0 in every state other than ABORT.
REQ-022 wbm_ack_i arriving in IDLE or ABORT SHALL be ignored: no ack is forwarded and the FSM does not change state.
REQ-023 If mN_cyc_i drops in the same cycle the counter hits TIMEOUT, the release SHALL win: no error is raised and the transition follows REQ-017.

Reset
REQ-024 wb_rst_n_i low SHALL force state=IDLE, last_grant=1 (so m0 wins the first tie), counter=0, and all outputs to 0, asynchronously.
REQ-025 Reset asserted mid-transfer SHALL drop wbm_cyc_o/wbm_stb_o immediately; after release, arbitration SHALL restart from IDLE.

Verification
REQ-026 Single request: m0 read, cyc/stb high at cycle 0, ack at cycle 3 with wbm_dat_i=0xDEADBEEF -> wbm_cyc_o high from cycle 1, m0_ack_o=1 and m0_dat_o=0xDEADBEEF at cycle 3, m1_ack_o=0.
REQ-027 Tie: m0 and m1 both request from reset -> GNT0 first; after m0 releases, GNT1 on the next edge with no IDLE cycle; next tie -> m0.
REQ-028 Burst hold: m1 runs 4 beats with m0 requesting throughout -> 4 acks forwarded only to m1; m0 is granted only after m1_cyc_i drops.
REQ-029 Timeout: TIMEOUT=4, m0 strobes, no ack -> m0_err_o=1 for one cycle after 4 stalled cycles, wbm_cyc_o=0 in ABORT, FSM returns to IDLE.
REQ-030 Reset mid-burst: wb_rst_n_i low during a GNT1 beat -> all outputs 0 at once; after release, a tie is granted to m0.
REQ-031 Stray ack: wbm_ack_i=1 in IDLE -> m0_ack_o=m1_ack_o=0, state unchanged.
